// File: rtl/ram_master.sv
//------------------------------------------------------------------------------
// Module      : ram_master
// Description : Burst initiator for a single-port synchronous RAM; sequences
//               one RAM access per cycle and streams read data back.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_master #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              M_cen,
  output logic              M_wen,
  output logic [ADDR_W-1:0] M_addr,
  output logic [DATA_W-1:0] M_dout,
  input  logic [DATA_W-1:0] M_din
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_write = 2'd1;
  localparam logic [1:0] c_read  = 2'd2;
  localparam logic [1:0] c_drain = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [ADDR_W-1:0] r_remain;
  logic              r_m_cen;
  logic              r_m_wen;
  logic              r_m_last;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_dout;
  logic              r_p1;
  logic              r_p1_last;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_done;
  logic              w_rd_final;
  logic              w_wr_final;
  logic              w_cmd_fire;
  logic              w_wr_fire;

  assign w_cmd_fire = cmd_valid && (r_state == c_idle);
  assign w_wr_fire  = wr_valid && (r_state == c_write);
  // r_m_last marks the access that ends the burst, so completion is seen as
  // it passes the RAM (write) or reaches the end of the return pipe (read).
  assign w_wr_final = r_m_cen && r_m_wen && r_m_last;
  assign w_rd_final = r_p1 && r_p1_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= c_idle;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle: begin
        if (cmd_valid) begin
          if (cmd_wr)              w_next = c_write;
          else if (cmd_len == '0)  w_next = c_drain;
          else                     w_next = c_read;
        end
      end
      c_write: if (wr_valid && (r_remain == '0)) w_next = c_drain;
      c_read:  if (r_remain == '0)               w_next = c_drain;
      default: if (w_rd_final || w_wr_final)     w_next = c_idle;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == c_idle);
    wr_ready  = (r_state == c_write);
    busy      = (r_state != c_idle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_addr <= '0;
      r_remain   <= '0;
      r_m_cen    <= 1'b0;
      r_m_wen    <= 1'b0;
      r_m_last   <= 1'b0;
      r_m_addr   <= '0;
      r_m_dout   <= '0;
    end else begin
      r_m_cen  <= 1'b0;
      r_m_wen  <= 1'b0;
      r_m_last <= 1'b0;
      if (w_cmd_fire) begin
        if (cmd_wr) begin
          r_cur_addr <= cmd_addr;
          r_remain   <= cmd_len;
        end else begin
          // First read goes out on the accepting edge.
          r_m_cen    <= 1'b1;
          r_m_addr   <= cmd_addr;
          r_m_last   <= (cmd_len == '0);
          r_cur_addr <= cmd_addr + ADDR_W'(1);
          r_remain   <= cmd_len - ADDR_W'(1);
        end
      end else if (w_wr_fire) begin
        r_m_cen    <= 1'b1;
        r_m_wen    <= 1'b1;
        r_m_addr   <= r_cur_addr;
        r_m_dout   <= wr_data;
        r_m_last   <= (r_remain == '0);
        r_cur_addr <= r_cur_addr + ADDR_W'(1);
        r_remain   <= r_remain - ADDR_W'(1);
      end else if (r_state == c_read) begin
        r_m_cen    <= 1'b1;
        r_m_addr   <= r_cur_addr;
        r_m_last   <= (r_remain == '0);
        r_cur_addr <= r_cur_addr + ADDR_W'(1);
        r_remain   <= r_remain - ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p1       <= 1'b0;
      r_p1_last  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_p1       <= r_m_cen && !r_m_wen;
      r_p1_last  <= r_m_cen && !r_m_wen && r_m_last;
      r_rd_valid <= r_p1;
      if (r_p1) r_rd_data <= M_din;
      r_done     <= w_rd_final || w_wr_final;
    end
  end

  assign M_cen    = r_m_cen;
  assign M_wen    = r_m_wen;
  assign M_addr   = r_m_addr;
  assign M_dout   = r_m_dout;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign done     = r_done;

endmodule

`default_nettype wire
